rr_mux_pipe: RTL and testbench
==============================

Name: rr_mux_pipe

Overview:
- Parametrised, registered N-channel data multiplexer with valid/ready handshakes.
- Each input lane is a stream. Lanes are selected either by an explicit select (fixed mode) or by a round-robin arbiter (rr mode).
- The winning lane is forwarded through a one-entry output register.
- Sits between multiple producers and a single consumer. It replaces single-cycle combinational 4:1 selection where backpressure and fairness are needed.

Parameters:
- N_CH, 4, number of input lanes; legal range 2..16.
- DATA_W, 8, width of each lane's data in bits.
- SEL_W, $clog2(N_CH), select/channel-index width; derived, not overridden.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  N_CH  per-lane valid; bit i belongs to lane i.
- in_ready  output  N_CH  per-lane ready; one-hot or zero.
- in_data  input  N_CH*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  lane index used when mode=0.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  DATA_W  registered data.
- out_ch  output  SEL_W  index of the lane that supplied out_data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - rr pointer ptr=0.
  - in_ready is all-zero while rst_n=0.
- load_en = ~out_valid | out_ready (combinational).
- Arbitration (combinational, evaluated every cycle):
  - mode=0: grant lane sel if in_valid[sel]=1. No grant if sel >= N_CH.
  - mode=1: grant the first lane with in_valid set, searching ptr, ptr+1, … wrapping modulo N_CH.
- in_ready[i] = grant[i] & load_en & rst_n. At most one bit is set, and no combinational path goes from in_valid to a non-granted lane's in_ready.
- Transfer on lane i: in_valid[i] & in_ready[i] at the clk edge.
  - Registers out_data = lane i data, out_ch = i, out_valid = 1.
  - Latency: input handshake at edge k gives out_valid high after edge k; data is visible in cycle k+1.
- Output drain: out_valid & out_ready with no new grant gives out_valid=0 at the next edge.
  - Simultaneous drain and load gives full throughput of 1 beat/cycle, with no bubble.
- Stall: out_valid=1 & out_ready=0:
  - out_data and out_ch are held stable.
  - All in_ready are 0.
- Pointer update:
  - Only on a transfer while mode=1: ptr = (granted index + 1) mod N_CH, wrapping N_CH-1 to 0.
  - Fixed-mode transfers leave ptr unchanged.
  - A mode change does not reset ptr.
- sel and mode are sampled only at the load point and may change freely between transfers.
- No grant while load_en=1: the register empties per the drain rule. Data is not modified when no load occurs.
- Reset mid-operation: any held beat is discarded (out_valid=0). No handshake completes in the reset cycle.

Optional Feature:
- Macro: RR_MUX_PIPE_BEAT_CNT_EN.
- When defined:
  - Adds output beat_cnt [15:0]: total completed output handshakes (out_valid & out_ready).
  - Saturates at 16'hFFFF; reset to 0.
  - Adds input cnt_clr: when high, a synchronous clear with priority over increment.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan (N_CH=4, DATA_W=8):
- Reset with all inputs active → out_valid=0, out_data=8'h00, out_ch=0, in_ready=4'b0000 throughout reset. The first grant after release is lane 0 in rr mode.
- mode=0, sel=2, in_valid=4'b1111, data lanes 0..3 = 8'hA0..8'hA3, out_ready=1 → in_ready=4'b0100 every cycle. out_data=8'hA2, out_ch=2 from the cycle after the first handshake, 1 beat/cycle.
- mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3. ptr wraps 3→0.
- mode=1, in_valid=4'b1010, ptr=0 → grants 1,3,1,3. Lanes 0 and 2 never get in_ready.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and out_data=8'h55 → out_data held at 8'h55, in_ready=0. On out_ready=1, the next beat loads in the same edge with no bubble.
- With RR_MUX_PIPE_BEAT_CNT_EN: 5 output handshakes → beat_cnt=5. cnt_clr coinciding with a handshake → beat_cnt=0. Preload to 16'hFFFF then 1 handshake → stays 16'hFFFF.

Source files
------------

// File: rtl/rr_mux_pipe.sv
// Registered N-lane stream mux with fixed-select or round-robin arbitration.
// Optional beat counter (beat_cnt/cnt_clr) enabled by RR_MUX_PIPE_BEAT_CNT_EN.
module rr_mux_pipe #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch
`ifdef RR_MUX_PIPE_BEAT_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [15:0]              beat_cnt
`endif
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(N_CH);

  logic [DATA_W-1:0] lane_data [N_CH];
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic [N_CH-1:0]   grant;
  logic              load_en;
  logic [SEL_W:0]    cand;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    assign lane_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  assign load_en = ~out_valid | out_ready;

  // Pick the winning lane; the rr search starts at ptr and wraps modulo N_CH.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!mode) begin
      if (({1'b0, sel} < NCH) && in_valid[sel]) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cand = {1'b0, ptr} + (SEL_W+1)'(i);
        if (cand >= NCH) cand = cand - NCH;
        if (!grant_any && in_valid[cand[SEL_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign in_ready = (rst_n && load_en) ? grant : '0;
  assign ptr_next = (grant_idx == SEL_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= lane_data[grant_idx];
        out_ch    <= grant_idx;
        if (mode) ptr <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_PIPE_BEAT_CNT_EN
  // Saturating count of completed output handshakes; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready && (beat_cnt != 16'hFFFF)) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_pipe.sv
// Randomized bench for rr_mux_pipe against a transaction-level reference model.
module tb_rr_mux_pipe;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           mode;
  logic [1:0]     sel;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
`ifdef RR_MUX_PIPE_BEAT_CNT_EN
  logic           cnt_clr;
  logic [15:0]    beat_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: what the output register, pointer and counter should hold
  bit       m_valid = 1'b0;
  bit [7:0] m_data  = 8'h00;
  int       m_ch    = 0;
  int       m_ptr   = 0;
  int       m_cnt   = 0;

  rr_mux_pipe #(.N_CH(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
`ifdef RR_MUX_PIPE_BEAT_CNT_EN
    , .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane that should win: explicit select, or first valid lane from ptr onward.
  function automatic int refGrant(input logic [N-1:0] v, input logic m, input int s, input int p);
    if (!m) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Drive one cycle, check in_ready mid-cycle, then check registered outputs after the edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic m,
                               input logic [1:0] s, input logic ordy, input logic rstn,
                               input logic clr);
    int g;
    bit ld;
    logic [N-1:0] exp_rdy;
    in_valid  = v;
    in_data   = d;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    rst_n     = rstn;
`ifdef RR_MUX_PIPE_BEAT_CNT_EN
    cnt_clr   = clr;
`endif
    #1;
    g  = refGrant(v, m, int'(s), m_ptr);
    ld = !m_valid || ordy;
    exp_rdy = '0;
    if (rstn && ld && g >= 0) exp_rdy[g] = 1'b1;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rstn) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (clr) m_cnt = 0;
      else if (m_valid && ordy && m_cnt < 16'hFFFF) m_cnt++;
      if (ld) begin
        if (g >= 0) begin
          m_valid = 1;
          m_data  = d[g*W +: W];
          m_ch    = g;
          if (m) m_ptr = (g + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
    end
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_data",  32'(out_data),  32'(m_data));
    checkOutput("out_ch",    32'(out_ch),    32'(m_ch));
`ifdef RR_MUX_PIPE_BEAT_CNT_EN
    checkOutput("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
`endif
  endtask

  localparam logic [N*W-1:0] LANES_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  initial begin
    logic [N*W-1:0] d;
    // Reset held with every input active
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, LANES_A, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    // First rr grant after release is lane 0, then full rotation with wrap
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, LANES_A, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    // Fixed select lane 2 at full throughput
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, LANES_A, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    // Sparse lanes from ptr=0: expect 1,3,1,3
    applyStimulus(4'b1111, LANES_A, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1010, LANES_A, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    // Backpressure holding 8'h55, then release with same-edge reload
    d = {8'h77, 8'h66, 8'h55, 8'h44};
    applyStimulus(4'b0010, d, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, LANES_A, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1111, LANES_A, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, LANES_A, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, LANES_A, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    // Randomized traffic with occasional reset and counter clear
    for (int i = 0; i < 600; i++) begin
      applyStimulus(4'($urandom), {$urandom}, 1'($urandom), 2'($urandom),
                    ($urandom % 4) != 0, ($urandom % 60) != 0, ($urandom % 16) == 0);
    end
`ifdef RR_MUX_PIPE_BEAT_CNT_EN
    // Counter: reset, 5 beats, clear during a handshake, then drive to saturation
    applyStimulus(4'b0000, LANES_A, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(4'b1111, LANES_A, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("cnt_five", 32'(beat_cnt), 32'd5);
    applyStimulus(4'b1111, LANES_A, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("cnt_clr", 32'(beat_cnt), 32'd0);
    for (int i = 0; i < 65540; i++) applyStimulus(4'b1111, LANES_A, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("cnt_sat", 32'(beat_cnt), 32'hFFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
